// File: rtl/screen_fill_if.sv
// Handshake and RAM-port bundle between the screen fill engine and its host/RAM side.
interface screen_fill_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) ();
  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] pattern;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic                  busy;
  logic                  cpu_stall;
  logic                  done;

  modport master (
    output start, mode, pattern, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, busy, cpu_stall, done
  );

  modport slave (
    input  start, mode, pattern, ram_rdata,
    output ram_addr, ram_wdata, ram_we, busy, cpu_stall, done
  );
endinterface

// File: rtl/screen_fill.sv
// Framebuffer fill engine: writes a generated pattern over the screen region of data RAM.
// All outputs are registered; next-state and next-output values are computed together.
module screen_fill #(
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH        = 12,
  parameter int RAM_SCREEN_OFFSET = 0,
  parameter int SCREEN_WORDS      = 24
) (
  input  logic         CLK_50,
  input  logic         reset,
  screen_fill_if.slave bus
);
  localparam int IDX_W = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(SCREEN_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(RAM_SCREEN_OFFSET);
  localparam logic [1:0] MODE_INC = 2'b01;
  localparam logic [1:0] MODE_INV = 2'b10;
  localparam logic [1:0] MODE_CHK = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          pattern_d = bus.pattern;
          idx_d     = '0;
          state_d   = (bus.mode == MODE_INV) ? READ : WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = (mode_q == MODE_INV) ? READ : WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Outputs for the coming cycle are decoded from the next state so they can be registered.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    ram_we_d = (state_d == WRITE);

    if ((state_d == READ) || (state_d == WRITE)) begin
      ram_addr_d = BASE + ADDR_WIDTH'(idx_d);
    end else begin
      ram_addr_d = '0;
    end

    // In invert mode the word read during READ is captured here on the READ->WRITE edge.
    if (state_d == WRITE) begin
      case (mode_d)
        MODE_INC: ram_wdata_d = pattern_d + DATA_WIDTH'(idx_d);
        MODE_INV: ram_wdata_d = ~bus.ram_rdata;
        MODE_CHK: ram_wdata_d = idx_d[0] ? ~pattern_d : pattern_d;
        default:  ram_wdata_d = pattern_d;
      endcase
    end else begin
      ram_wdata_d = '0;
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mode_q      <= 2'b00;
      pattern_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_stall = busy_q;
  assign bus.done      = done_q;
endmodule
